// File: rtl/ring_insertion_pkg.sv
// Shared types and helpers for the ring insertion node: arbitration mode,
// statistics width and the round-robin picker used for injection sources.
package ring_insertion_pkg;

  typedef enum logic [0:0] {
    MODE_NORMAL    = 1'b0,
    MODE_RING_PRIO = 1'b1
  } mode_e;

  localparam int STATS_WIDTH   = 16;
  // Upper bound on injection sources handled by rr_pick
  localparam int MAX_INJ       = 16;
  localparam int MAX_INJ_IDX_W = 4;

  // One-hot round-robin pick: first set bit of valid[n-1:0] starting at ptr,
  // wrapping modulo n. Returns zero when nothing is valid.
  function automatic logic [MAX_INJ-1:0] rr_pick(
    input logic [MAX_INJ-1:0] valid,
    input int unsigned        n,
    input int unsigned        ptr
  );
    logic [MAX_INJ-1:0]       grant;
    logic [MAX_INJ_IDX_W-1:0] idx;
    logic                     found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_INJ; off++) begin
      if (off < n) begin
        idx = MAX_INJ_IDX_W'((ptr + off) % n);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/ring_insertion_node_fifo.sv
// Return FIFO for ring tokens coming back from the last station.
// Registered count; a push while full is refused even if a pop happens.
module ring_return_fifo #(
  parameter int DWIDTH     = 9,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DWIDTH-1:0]     wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DWIDTH-1:0]     rd_data,
  input  logic                  rd_ready,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CNT_W = DEPTH_BITS + 1;
  localparam logic [DEPTH_BITS:0]   FULL_COUNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);

  logic [DWIDTH-1:0]     mem_r [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_r;
  logic [DEPTH_BITS-1:0] rd_ptr_r;
  logic [DEPTH_BITS:0]   count_r;
  logic                  push_s;
  logic                  pop_s;

  assign full     = (count_r == FULL_COUNT);
  assign empty    = (count_r == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign push_s   = wr_valid && !full;
  assign pop_s    = rd_ready && !empty;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers wrap naturally; count tracks occupancy one bit wider
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ring_insertion_node.sv
// Ring-closure node: merges the ring return path with N_INJ injection sources
// into station 0. Injections win round-robin by default; a starve counter and
// FIFO-full escalation force ring tokens through so the ring keeps moving.
// Optional grant statistics under macro RING_INSERTION_STATS_EN.
module ring_insertion_node
  import ring_insertion_pkg::*;
#(
  parameter int DWIDTH          = 9,
  parameter int N_INJ           = 2,
  parameter int FIFO_DEPTH_BITS = 2,
  parameter int STARVE_LIMIT    = 15,
  parameter int STARVE_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_INJ-1:0]          inj_valid,
  input  logic [N_INJ*DWIDTH-1:0]   inj_data,
  output logic [N_INJ-1:0]          inj_ready,
  input  logic                      ring_in_valid,
  input  logic [DWIDTH-1:0]         ring_in_data,
  output logic                      ring_in_ready,
  output logic                      ring_out_valid,
  output logic [DWIDTH-1:0]         ring_out_data,
  input  logic                      ring_out_ready,
  output logic [FIFO_DEPTH_BITS:0]  fifo_count,
  output logic                      any_in_flight,
  output logic [STATS_WIDTH-1:0]    inj_grant_count,
  output logic [STATS_WIDTH-1:0]    ring_grant_count
);

  localparam int PTR_W = (N_INJ > 1) ? $clog2(N_INJ) : 1;
  localparam logic [STARVE_WIDTH-1:0] STARVE_LIMIT_C = STARVE_WIDTH'(STARVE_LIMIT);
  localparam logic [STARVE_WIDTH-1:0] STARVE_ONE     = STARVE_WIDTH'(1);

  logic                     loadable_s;
  logic [N_INJ-1:0]         inj_gnt_s;
  logic                     inj_gnt_any_s;
  logic                     ring_gnt_s;
  logic [MAX_INJ-1:0]       pick_s;
  logic                     unused_pick_s;
  logic [DWIDTH-1:0]        inj_sel_data_s;
  logic [PTR_W-1:0]         ptr_next_s;
  logic [PTR_W-1:0]         rr_ptr_r;
  logic                     ring_out_valid_r;
  logic [DWIDTH-1:0]        ring_out_data_r;
  logic [STARVE_WIDTH-1:0]  starve_r;
  mode_e                    mode_r;

  logic                     fifo_wr_ready_s;
  logic                     fifo_rd_valid_s;
  logic [DWIDTH-1:0]        fifo_rd_data_s;
  logic [FIFO_DEPTH_BITS:0] fifo_count_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;

  ring_return_fifo #(
    .DWIDTH     (DWIDTH),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (ring_in_valid),
    .wr_data  (ring_in_data),
    .wr_ready (fifo_wr_ready_s),
    .rd_valid (fifo_rd_valid_s),
    .rd_data  (fifo_rd_data_s),
    .rd_ready (ring_gnt_s),
    .count    (fifo_count_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

  assign loadable_s     = !ring_out_valid_r || ring_out_ready;
  assign inj_gnt_any_s  = |inj_gnt_s;
  assign unused_pick_s  = ^pick_s;
  assign inj_ready      = inj_gnt_s;
  assign ring_in_ready  = fifo_wr_ready_s;
  assign ring_out_valid = ring_out_valid_r;
  assign ring_out_data  = ring_out_data_r;
  assign fifo_count     = fifo_count_s;
  assign any_in_flight  = !fifo_empty_s || ring_out_valid_r;

  // Arbitration: only when the output register can take a token
  always_comb begin
    inj_gnt_s  = '0;
    ring_gnt_s = 1'b0;
    pick_s     = '0;
    if (loadable_s) begin
      case (mode_r)
        MODE_NORMAL: begin
          if (|inj_valid) begin
            pick_s    = rr_pick(MAX_INJ'(inj_valid), N_INJ, 32'(rr_ptr_r));
            inj_gnt_s = pick_s[N_INJ-1:0];
          end else begin
            ring_gnt_s = fifo_rd_valid_s;
          end
        end
        MODE_RING_PRIO: ring_gnt_s = fifo_rd_valid_s;
        default:        ring_gnt_s = 1'b0;
      endcase
    end else begin
      ring_gnt_s = 1'b0;
    end
  end

  // Select the granted injection token and the pointer just past it
  always_comb begin
    inj_sel_data_s = '0;
    ptr_next_s     = rr_ptr_r;
    for (int i = 0; i < N_INJ; i++) begin
      if (inj_gnt_s[i]) begin
        inj_sel_data_s = inj_data[i*DWIDTH +: DWIDTH];
        ptr_next_s     = PTR_W'((i + 1) % N_INJ);
      end else begin
      end
    end
  end

  // Output register: load on grant, hold until accepted, clear when drained
  always_ff @(posedge clk) begin
    if (!rst) begin
      ring_out_valid_r <= 1'b0;
      ring_out_data_r  <= '0;
    end else if (inj_gnt_any_s) begin
      ring_out_valid_r <= 1'b1;
      ring_out_data_r  <= inj_sel_data_s;
    end else if (ring_gnt_s) begin
      ring_out_valid_r <= 1'b1;
      ring_out_data_r  <= fifo_rd_data_s;
    end else if (loadable_s) begin
      ring_out_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer advances past each granted injection source
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (inj_gnt_any_s) begin
      rr_ptr_r <= ptr_next_s;
    end
  end

  // Starve counter: cycles a ring token waits without being granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_r <= '0;
    end else if (!fifo_empty_s && !ring_gnt_s) begin
      if (starve_r != STARVE_LIMIT_C) begin
        starve_r <= starve_r + STARVE_ONE;
      end
    end else begin
      starve_r <= '0;
    end
  end

  // Mode FSM: escalate to ring priority on starvation or a full return FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_r <= MODE_NORMAL;
    end else begin
      case (mode_r)
        MODE_NORMAL: begin
          if (starve_r == STARVE_LIMIT_C || fifo_full_s) begin
            mode_r <= MODE_RING_PRIO;
          end else begin
            mode_r <= MODE_NORMAL;
          end
        end
        MODE_RING_PRIO: begin
          if (ring_gnt_s && !fifo_full_s) begin
            mode_r <= MODE_NORMAL;
          end else begin
            mode_r <= MODE_RING_PRIO;
          end
        end
        default: mode_r <= MODE_NORMAL;
      endcase
    end
  end

`ifdef RING_INSERTION_STATS_EN
  logic [STATS_WIDTH-1:0] inj_cnt_r;
  logic [STATS_WIDTH-1:0] ring_cnt_r;

  // Saturating grant counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      inj_cnt_r  <= '0;
      ring_cnt_r <= '0;
    end else begin
      if (inj_gnt_any_s && inj_cnt_r != '1) begin
        inj_cnt_r <= inj_cnt_r + STATS_WIDTH'(1);
      end
      if (ring_gnt_s && ring_cnt_r != '1) begin
        ring_cnt_r <= ring_cnt_r + STATS_WIDTH'(1);
      end
    end
  end

  assign inj_grant_count  = inj_cnt_r;
  assign ring_grant_count = ring_cnt_r;
`else
  assign inj_grant_count  = '0;
  assign ring_grant_count = '0;
`endif

endmodule

// File: tb/tb_ring_insertion_node.sv
// Self-checking bench for ring_insertion_node: directed scenarios plus random
// traffic, all checked against a queue-based behavioural model of the node.
module tb_ring_insertion_node;

  localparam int DW    = 9;
  localparam int NI    = 2;
  localparam int DB    = 2;
  localparam int DEPTH = 4;
  localparam int LIMIT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI-1:0]     inj_valid;
  logic [NI*DW-1:0]  inj_data;
  logic [NI-1:0]     inj_ready;
  logic              ring_in_valid;
  logic [DW-1:0]     ring_in_data;
  logic              ring_in_ready;
  logic              ring_out_valid;
  logic [DW-1:0]     ring_out_data;
  logic              ring_out_ready;
  logic [DB:0]       fifo_count;
  logic              any_in_flight;
  logic [15:0]       inj_grant_count;
  logic [15:0]       ring_grant_count;

  always #5 clk = ~clk;

  ring_insertion_node dut (
    .clk              (clk),
    .rst              (rst),
    .inj_valid        (inj_valid),
    .inj_data         (inj_data),
    .inj_ready        (inj_ready),
    .ring_in_valid    (ring_in_valid),
    .ring_in_data     (ring_in_data),
    .ring_in_ready    (ring_in_ready),
    .ring_out_valid   (ring_out_valid),
    .ring_out_data    (ring_out_data),
    .ring_out_ready   (ring_out_ready),
    .fifo_count       (fifo_count),
    .any_in_flight    (any_in_flight),
    .inj_grant_count  (inj_grant_count),
    .ring_grant_count (ring_grant_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  logic [DW-1:0] mq[$];
  logic          m_ov;
  logic [DW-1:0] m_od;
  int            m_ptr;
  int            m_starve;
  bit            m_prio;
  int            m_inj_cnt;
  int            m_ring_cnt;
  int            g_k;
  bit            g_ring;
  bit            g_load;

  task automatic model_reset();
    mq.delete();
    m_ov = 1'b0; m_od = '0; m_ptr = 0; m_starve = 0; m_prio = 1'b0;
    m_inj_cnt = 0; m_ring_cnt = 0;
  endtask

  task automatic model_grant();
    g_load = !m_ov || ring_out_ready;
    g_k    = -1;
    g_ring = 1'b0;
    if (g_load) begin
      if (!m_prio && inj_valid != '0) begin
        for (int off = 0; off < NI; off++) begin
          int idx;
          idx = (m_ptr + off) % NI;
          if (g_k < 0 && inj_valid[idx]) g_k = idx;
        end
      end else if (mq.size() > 0) begin
        g_ring = 1'b1;
      end
    end
  endtask

  // One clock: check DUT against model, cross the edge, advance the model
  task automatic step();
    logic [31:0] exp_rdy, exp_ic, exp_rc;
    bit          full_b;
    int          starve_old;
    #1;
    model_grant();
    exp_rdy = (g_k >= 0) ? (32'd1 << g_k) : 32'd0;
    if (rst) begin
      chk("inj_ready", 32'(inj_ready), exp_rdy);
      chk("ring_in_ready", 32'(ring_in_ready), 32'(mq.size() < DEPTH));
    end
    chk("out_valid", 32'(ring_out_valid), 32'(m_ov));
    chk("out_data", 32'(ring_out_data), 32'(m_od));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("in_flight", 32'(any_in_flight), 32'((mq.size() != 0) || m_ov));
`ifdef RING_INSERTION_STATS_EN
    exp_ic = 32'(m_inj_cnt);
    exp_rc = 32'(m_ring_cnt);
`else
    exp_ic = 32'd0;
    exp_rc = 32'd0;
`endif
    chk("inj_grant_count", 32'(inj_grant_count), exp_ic);
    chk("ring_grant_count", 32'(ring_grant_count), exp_rc);
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      full_b     = (mq.size() == DEPTH);
      starve_old = m_starve;
      if (mq.size() != 0 && !g_ring) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
      if (g_k >= 0) begin
        m_od  = inj_data[g_k*DW +: DW];
        m_ov  = 1'b1;
        m_ptr = (g_k + 1) % NI;
        if (m_inj_cnt < 65535) m_inj_cnt++;
      end else if (g_ring) begin
        m_od = mq.pop_front();
        m_ov = 1'b1;
        if (m_ring_cnt < 65535) m_ring_cnt++;
      end else if (g_load) begin
        m_ov = 1'b0;
      end
      if (ring_in_valid && !full_b) mq.push_back(ring_in_data);
      if (!m_prio) m_prio = (starve_old == LIMIT) || full_b;
      else if (g_ring && !full_b) m_prio = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inj_valid = '0; inj_data = '0; ring_in_valid = 1'b0; ring_in_data = '0; ring_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  logic [1:0]    want;
  logic [DW-1:0] d0, d1;
  int            n;
  bit            found;

  initial begin
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(ring_out_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_inflight", 32'(any_in_flight), 32'd0);

    // Injection latency and hold while not accepted
    do_reset();
    inj_valid = 2'b01;
    d0 = 9'h0A5; d1 = 9'h033; inj_data = {d1, d0};
    #1 chk("lat_rdy", 32'(inj_ready), 32'd1);
    step();
    chk("lat_valid", 32'(ring_out_valid), 32'd1);
    chk("lat_data", 32'(ring_out_data), 32'h0A5);
    inj_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_rdy", 32'(inj_ready), 32'd0);
      step();
      chk("hold_valid", 32'(ring_out_valid), 32'd1);
      chk("hold_data", 32'(ring_out_data), 32'h0A5);
    end

    // Round-robin alternation
    do_reset();
    ring_out_ready = 1'b1;
    inj_valid = 2'b11;
    want = 2'b01;
    for (int i = 0; i < 8; i++) begin
      d0 = 9'(32'h010 + i); d1 = 9'(32'h100 + i); inj_data = {d1, d0};
      #1 chk("rr_gnt", 32'(inj_ready), 32'(want));
      step();
      chk("rr_data", 32'(ring_out_data), (want == 2'b01) ? 32'(d0) : 32'(d1));
      want = ~want;
    end

    // Starvation escalation: 16 injection grants, then the ring token
    do_reset();
    ring_out_ready = 1'b1;
    inj_valid = 2'b11;
    d0 = 9'h0C0; d1 = 9'h0C1; inj_data = {d1, d0};
    ring_in_valid = 1'b1; ring_in_data = 9'h1FF;
    step();
    ring_in_valid = 1'b0;
    found = 1'b0; n = 0;
    for (int i = 1; i <= 40 && !found; i++) begin
      step();
      if (ring_out_valid && ring_out_data == 9'h1FF) begin
        found = 1'b1; n = i;
      end
    end
    chk("starve_lat", 32'(n), 32'd17);
    #1 chk("starve_back", 32'(inj_ready), 32'(2'b10));
    step();

    // FIFO full escalation and in-order drain
    do_reset();
    for (int t = 1; t <= 6; t++) begin
      ring_in_valid = 1'b1; ring_in_data = 9'(32'h100 + t);
      step();
    end
    ring_in_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 32'd4);
    #1 chk("full_rdy", 32'(ring_in_ready), 32'd0);
    inj_valid = 2'b11; ring_out_ready = 1'b1;
    #1 chk("full_prio", 32'(inj_ready), 32'd0);
    step();
    chk("drain", 32'(ring_out_data), 32'h102);
    inj_valid = 2'b00;
    for (int t = 3; t <= 5; t++) begin
      step();
      chk("drain", 32'(ring_out_data), 32'(32'h100 + t));
    end
    step();
    chk("drain_empty", 32'(any_in_flight), 32'd0);

    // Reset in the middle of traffic drops everything
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      ring_in_valid = 1'b1; ring_in_data = 9'(32'h040 + t);
      step();
    end
    ring_in_valid = 1'b0;
    chk("mid_count", 32'(fifo_count), 32'd3);
    chk("mid_valid", 32'(ring_out_valid), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(ring_out_valid), 32'd0);
    chk("mid_rst_inflight", 32'(any_in_flight), 32'd0);
    chk("mid_rst_ic", 32'(inj_grant_count), 32'd0);
    chk("mid_rst_rc", 32'(ring_grant_count), 32'd0);

    // Statistics: 5 injection grants, 3 ring grants
    do_reset();
    ring_out_ready = 1'b1;
    inj_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      inj_data = (NI*DW)'($urandom);
      step();
    end
    inj_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      ring_in_valid = 1'b1; ring_in_data = 9'(32'h0E0 + i);
      step();
    end
    ring_in_valid = 1'b0;
    repeat (3) step();
`ifdef RING_INSERTION_STATS_EN
    chk("stats_inj", 32'(inj_grant_count), 32'd5);
    chk("stats_ring", 32'(ring_grant_count), 32'd3);
`else
    chk("stats_inj", 32'(inj_grant_count), 32'd0);
    chk("stats_ring", 32'(ring_grant_count), 32'd0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 199) != 0);
      inj_valid      = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
      inj_data       = (NI*DW)'($urandom);
      ring_in_valid  = ($urandom_range(0, 2) != 0);
      ring_in_data   = DW'($urandom);
      ring_out_ready = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
